// File: rtl/decode_stage.sv
// RV64I decode stage: a 2-entry skid buffer of {pc, instr, decoded fields} between fetch and execute.
// Decode is combinational on f_instr and captured on accept; f_ready is a pure flop output.
module decode_stage #(
  parameter int XLEN     = 64,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                f_valid,
  input  logic [PC_WIDTH-1:0] f_pc,
  input  logic [31:0]         f_instr,
  output logic                f_ready,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [PC_WIDTH-1:0] d_pc,
  output logic [31:0]         d_instr,
  output logic [6:0]          d_opcode,
  output logic [2:0]          d_funct3,
  output logic [6:0]          d_funct7,
  output logic [4:0]          d_rd,
  output logic [4:0]          d_rs1,
  output logic [4:0]          d_rs2,
  output logic [XLEN-1:0]     d_imm,
  output logic                d_illegal
);

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         instr;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [XLEN-1:0]     imm;
    logic                illegal;
  } entry_t;

  fmt_e   fmt;
  entry_t new_e;
  entry_t main_d, main_q;
  entry_t skid_d, skid_q;
  logic   main_valid_d, main_valid_q;
  logic   skid_valid_d, skid_valid_q;
  logic   f_ready_d, f_ready_q;
  logic   accept, consume;

  always_comb begin
    unique case (f_instr[6:0])
      7'b0110111, 7'b0010111: fmt = FMT_U;
      7'b1101111:             fmt = FMT_J;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0011011,
      7'b1110011, 7'b0001111: fmt = FMT_I;
      7'b0100011:             fmt = FMT_S;
      7'b1100011:             fmt = FMT_B;
      7'b0110011, 7'b0111011: fmt = FMT_R;
      default:                fmt = FMT_BAD;
    endcase
    if (f_instr[1:0] != 2'b11) fmt = FMT_BAD;
  end

  always_comb begin
    new_e         = '0;
    new_e.pc      = f_pc;
    new_e.instr   = f_instr;
    new_e.rd      = f_instr[11:7];
    new_e.rs1     = f_instr[19:15];
    new_e.rs2     = f_instr[24:20];
    new_e.illegal = (fmt == FMT_BAD);
    unique case (fmt)
      FMT_I: begin
        new_e.rs2 = '0;
        new_e.imm = {{(XLEN-12){f_instr[31]}}, f_instr[31:20]};
      end
      FMT_S: begin
        new_e.rd  = '0;
        new_e.imm = {{(XLEN-12){f_instr[31]}}, f_instr[31:25], f_instr[11:7]};
      end
      FMT_B: begin
        new_e.rd  = '0;
        new_e.imm = {{(XLEN-13){f_instr[31]}}, f_instr[31], f_instr[7],
                     f_instr[30:25], f_instr[11:8], 1'b0};
      end
      FMT_U: begin
        new_e.rs1 = '0;
        new_e.rs2 = '0;
        new_e.imm = {{(XLEN-32){f_instr[31]}}, f_instr[31:12], 12'b0};
      end
      FMT_J: begin
        new_e.rs1 = '0;
        new_e.rs2 = '0;
        new_e.imm = {{(XLEN-21){f_instr[31]}}, f_instr[31], f_instr[19:12],
                     f_instr[20], f_instr[30:21], 1'b0};
      end
      default: new_e.imm = '0;
    endcase
  end

  assign accept  = f_valid & f_ready_q & ~flush;
  assign consume = main_valid_q & d_ready;

  // f_ready was low whenever skid is valid, so a refill of skid never coincides with draining it.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = new_e;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_d       = new_e;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = new_e;
        main_valid_d = 1'b1;
      end
    end
    f_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      f_ready_q    <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      f_ready_q    <= f_ready_d;
    end
  end

  assign f_ready   = f_ready_q;
  assign d_valid   = main_valid_q;
  assign d_pc      = main_q.pc;
  assign d_instr   = main_q.instr;
  assign d_opcode  = main_q.instr[6:0];
  assign d_funct3  = main_q.instr[14:12];
  assign d_funct7  = main_q.instr[31:25];
  assign d_rd      = main_q.rd;
  assign d_rs1     = main_q.rs1;
  assign d_rs2     = main_q.rs2;
  assign d_imm     = main_q.imm;
  assign d_illegal = main_q.illegal;

endmodule
